// File: rtl/booth_product_accumulator.sv
// Accumulates a programmable number of signed Booth products into a wide
// accumulator and holds the sum on a result handshake. Optional macro:
// BOOTH_ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module booth_product_accumulator #(
    parameter int PW = 64,
    parameter int AW = 72,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] len,
    output logic          busy,
    input  logic          prod_valid,
    input  logic [PW-1:0] prod_data,
    output logic          prod_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data,
    output logic          res_ovf,
    output logic [CW-1:0] res_count
);

    // Handshakes: a product moves on a cycle with prod_valid && prod_ready;
    // the result moves on a cycle with res_valid && res_ready. Both ready and
    // valid outputs are decoded purely from the state register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] acc, prod_ext, sum;
    logic [CW-1:0] cnt, len_q;
    logic          ovf, xfer, last, ovf_now;

    generate
        if (AW > PW) begin : g_sext
            assign prod_ext = {{(AW-PW){prod_data[PW-1]}}, prod_data};
        end else begin : g_same
            assign prod_ext = prod_data;
        end
    endgenerate

    assign xfer    = (state == ACC) && prod_valid;
    assign last    = xfer && (cnt == len_q - CW'(1));
    assign sum     = acc + prod_ext;
    // Same-signed operands whose sum flips sign have left the AW-bit range.
    assign ovf_now = (acc[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc[AW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len != '0) ? ACC : HOLD;
            ACC:  if (last) state_nxt = HOLD;
            HOLD: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (xfer) begin
            cnt <= cnt + CW'(1);
            if (ovf_now) ovf <= 1'b1;
`ifdef BOOTH_ACC_SAT_EN
            if (ovf_now) acc <= acc[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            else         acc <= sum;
`else
            acc <= sum;
`endif
        end
    end

    assign busy       = (state != IDLE);
    assign prod_ready = (state == ACC);
    assign res_valid  = (state == HOLD);
    // Accumulator state is only touched on start or transfer, so it is stable in HOLD.
    assign res_data   = acc;
    assign res_count  = cnt;
    assign res_ovf    = ovf;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Randomized bench for booth_product_accumulator against an exact-arithmetic
// reference model; honours BOOTH_ACC_SAT_EN in the model as well.
module tb_booth_product_accumulator;

    localparam int PW = 64;
    localparam int AW = 72;
    localparam int CW = 16;
    localparam int RW = 1 + CW + AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          busy;
    logic          prod_valid = 1'b0;
    logic [PW-1:0] prod_data = '0;
    logic          prod_ready;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;
    logic          res_ovf;
    logic [CW-1:0] res_count;

    logic [PW-1:0] job_q[$];
    logic [RW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    booth_product_accumulator #(.PW(PW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_count(res_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    // Exact running sum, then wrap or clamp whenever it leaves the AW-bit range.
    function automatic logic [RW-1:0] model_result();
        logic signed [127:0] a, s, hi, lo;
        logic o;
        hi = (128'sd1 <<< (AW-1)) - 128'sd1;
        lo = -(128'sd1 <<< (AW-1));
        a = '0;
        o = 1'b0;
        foreach (job_q[i]) begin
            s = a + {{(128-PW){job_q[i][PW-1]}}, job_q[i]};
            if (s > hi || s < lo) begin
                o = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
                s = (s > hi) ? hi : lo;
`else
                s = {{(128-AW){s[AW-1]}}, s[AW-1:0]};
`endif
            end
            a = s;
        end
        return {o, CW'(job_q.size()), a[AW-1:0]};
    endfunction

    task automatic do_start(input int l);
        job_q.delete();
        start = 1'b1;
        len = CW'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [PW-1:0] p, input int gap);
        repeat (gap) @(negedge clk);
        prod_valid = 1'b1;
        prod_data = p;
        for (int t = 0; t < 50 && !prod_ready; t++) @(negedge clk);
        check_val("prod_ready", prod_ready, 1);
        @(negedge clk);
        prod_valid = 1'b0;
        job_q.push_back(p);
    endtask

    task automatic push_model();
        exp_q.push_back(model_result());
    endtask

    task automatic collect(input int hold, input logic poke);
        logic [RW-1:0] e;
        for (int t = 0; t < 50 && !res_valid; t++) @(negedge clk);
        check_val("res_valid", res_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_val("res_data", res_data, e[AW-1:0]);
        check_val("res_count", res_count, e[AW+CW-1:AW]);
        check_val("res_ovf", res_ovf, e[RW-1]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_stable", {res_valid, prod_ready, res_ovf, res_count, res_data}, {2'b10, e});
        end
        res_ready = 1'b1;
        if (poke) begin
            start = 1'b1;
            len = CW'(7);
        end
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        check_val("idle_after_ack", {busy, res_valid}, 2'b00);
    endtask

    function automatic logic [PW-1:0] rand_prod();
        case ($urandom_range(0, 3))
            0: return {1'b0, {(PW-1){1'b1}}};
            1: return {1'b1, {(PW-1){1'b0}}};
            2: return {{(PW-16){1'b0}}, 16'($urandom)} - PW'(32768);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check_val("reset_outs", {busy, prod_ready, res_valid, res_ovf, res_count, res_data}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum with one-cycle result latency
        do_start(3);
        send(64'd5, 0);
        send(-64'sd7, 0);
        send(64'd100, 0);
        check_val("latency", res_valid, 1);
        push_model();
        collect(1, 1'b0);

        // Zero length with products offered throughout
        prod_valid = 1'b1;
        prod_data = 64'd55;
        do_start(0);
        check_val("zero_len_hold", {res_valid, prod_ready}, 2'b10);
        push_model();
        collect(3, 1'b0);
        check_val("zero_len_idle_ready", prod_ready, 0);
        prod_valid = 1'b0;

        // Gaps, backpressure and a start poked while the result is acknowledged
        do_start(2);
        send(64'hFFFF_FFFF_0000_0000, 0);
        send(64'h0000_0001_0000_0000, 4);
        push_model();
        collect(5, 1'b1);

        // Start ignored while accumulating
        do_start(2);
        send(64'd11, 0);
        start = 1'b1;
        len = CW'(4);
        @(negedge clk);
        start = 1'b0;
        send(64'd22, 0);
        check_val("len_kept", res_valid, 1);
        push_model();
        collect(0, 1'b0);

        // Positive then negative overflow of the 72-bit accumulator
        do_start(257);
        for (int i = 0; i < 257; i++) send({1'b0, {(PW-1){1'b1}}}, 0);
        push_model();
        collect(0, 1'b0);
        do_start(258);
        for (int i = 0; i < 258; i++) send({1'b1, {(PW-1){1'b0}}}, 0);
        push_model();
        collect(0, 1'b0);

        // Asynchronous reset mid-run discards the partial sum
        do_start(5);
        send(64'd1234, 0);
        send(64'd99, 0);
        #2 rst_n = 1'b0;
        #1 check_val("async_reset", {busy, prod_ready, res_valid, res_ovf, res_count, res_data}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("no_res_after_reset", res_valid, 0);
        do_start(1);
        send(-64'sd3, 0);
        push_model();
        collect(0, 1'b0);

        // Random jobs
        for (int j = 0; j < 12; j++) begin
            int l;
            l = $urandom_range(1, 9);
            do_start(l);
            for (int i = 0; i < l; i++) send(rand_prod(), $urandom_range(0, 2));
            push_model();
            collect($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
